// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer controller: gates requests against full/empty, drives
// dual-port RAM enables/addresses, and exports occupancy, level flags and Gray pointers.
module sync_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   wr_gray,
  output logic [ADDR_WIDTH:0]   rd_gray
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Status is decoded straight from the registered pointers; the MSB disambiguates full/empty.
  always_comb begin
    empty        = (wr_bin_q == rd_bin_q);
    full         = (wr_bin_q[PW-1] != rd_bin_q[PW-1]) &&
                   (wr_bin_q[PW-2:0] == rd_bin_q[PW-2:0]);
    count        = wr_bin_q - rd_bin_q;
    almost_full  = (count >= PW'(AF_LEVEL));
    almost_empty = (count <= PW'(AE_LEVEL));
    wr_en        = wr_req & ~full;
    rd_en        = rd_req & ~empty;
    wr_addr      = wr_bin_q[PW-2:0];
    rd_addr      = rd_bin_q[PW-2:0];
  end

  // Next-state: Gray is encoded from the next binary value so it never lags the pointer.
  always_comb begin
    wr_bin_d    = wr_bin_q + PW'(wr_en);
    rd_bin_d    = rd_bin_q + PW'(rd_en);
    wr_gray_d   = bin2gray(wr_bin_d);
    rd_gray_d   = bin2gray(rd_bin_d);
    rd_valid_d  = rd_en;
    overflow_d  = wr_req & full;
    underflow_d = rd_req & empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin_q    <= '0;
      rd_bin_q    <= '0;
      wr_gray_q   <= '0;
      rd_gray_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_bin_q    <= wr_bin_d;
      rd_bin_q    <= rd_bin_d;
      wr_gray_q   <= wr_gray_d;
      rd_gray_q   <= rd_gray_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign wr_gray   = wr_gray_q;
  assign rd_gray   = rd_gray_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised + directed bench for sync_fifo_ctrl against a queue-based occupancy model.
module tb_sync_fifo_ctrl;

  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam int          PTRM  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          wr_en, rd_en, rd_valid, full, empty, almost_full, almost_empty;
  logic          overflow, underflow;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [AW:0]   count, wr_gray, rd_gray;

  sync_fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .wr_gray(wr_gray), .rd_gray(rd_gray)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: a queue of slot addresses written but not yet read, plus total-operation counters.
  int m_q[$];
  int m_wr_ops = 0;
  int m_rd_ops = 0;
  bit m_rdv = 0, m_ovf = 0, m_unf = 0;
  bit m_known = 0;
  bit gray_prev_ok = 0;
  logic [AW:0] gray_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW:0] gray_of(input int ops);
    logic [AW:0] b;
    b = (AW+1)'(ops % PTRM);
    return b ^ (b >> 1);
  endfunction

  // One clock cycle: apply inputs, check at negedge, advance model at posedge.
  task automatic step(input bit r, input bit w, input bit rd);
    int  n;
    bit  acc_w, acc_r;
    rst = r; wr_req = w; rd_req = rd;
    @(negedge clk);
    n = m_q.size();
    if (m_known) begin
      chk("count",     32'(count),        32'(n));
      chk("empty",     32'(empty),        32'(n == 0));
      chk("full",      32'(full),         32'(n == DEPTH));
      chk("a_full",    32'(almost_full),  32'(n >= 12));
      chk("a_empty",   32'(almost_empty), 32'(n <= 2));
      chk("wr_en",     32'(wr_en),        32'(w && n != DEPTH));
      chk("rd_en",     32'(rd_en),        32'(rd && n != 0));
      chk("wr_addr",   32'(wr_addr),      32'(m_wr_ops % DEPTH));
      chk("rd_addr",   32'(rd_addr),      32'(m_rd_ops % DEPTH));
      if (n != 0) chk("rd_head", 32'(rd_addr), 32'(m_q[0]));
      chk("wr_gray",   32'(wr_gray),      32'(gray_of(m_wr_ops)));
      chk("rd_gray",   32'(rd_gray),      32'(gray_of(m_rd_ops)));
      chk("rd_valid",  32'(rd_valid),     32'(m_rdv));
      chk("overflow",  32'(overflow),     32'(m_ovf));
      chk("underflow", 32'(underflow),    32'(m_unf));
      if (gray_prev_ok)
        chk("gray_step", 32'($countones(gray_prev ^ wr_gray) <= 1), 32'd1);
      gray_prev    = wr_gray;
      gray_prev_ok = 1'b1;
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_wr_ops = 0; m_rd_ops = 0;
      m_rdv = 0; m_ovf = 0; m_unf = 0;
      m_known = 1;
      gray_prev_ok = 0;
    end else begin
      acc_w = w && (n != DEPTH);
      acc_r = rd && (n != 0);
      m_rdv = acc_r;
      m_ovf = w && (n == DEPTH);
      m_unf = rd && (n == 0);
      if (acc_r) begin void'(m_q.pop_front()); m_rd_ops = (m_rd_ops + 1) % PTRM; end
      if (acc_w) begin m_q.push_back(m_wr_ops % DEPTH); m_wr_ops = (m_wr_ops + 1) % PTRM; end
    end
    #1;
  endtask

  initial begin
    int wp, rp;
    #1;
    // Reset with both requests high
    step(1, 1, 1);
    step(1, 1, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_gray",  32'(wr_gray), 32'd0);
    // Fill plus one rejected write
    for (int i = 0; i < 17; i++) step(0, 1, 0);
    chk("fill_gray", 32'(wr_gray), 32'h18);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf",  32'(overflow), 32'd1);
    // Drain plus one rejected read
    for (int i = 0; i < 17; i++) step(0, 0, 1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_unf",   32'(underflow), 32'd1);
    chk("drain_rdv",   32'(rd_valid), 32'd0);
    step(0, 0, 0);
    // Simultaneous at full, at empty, at mid-level
    for (int i = 0; i < 16; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("sim_full_cnt", 32'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    step(0, 1, 1);
    chk("sim_empty_cnt", 32'(count), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 1, 1);
    chk("sim_mid_cnt", 32'(count), 32'd5);
    // Wrap-around with paired operations
    for (int i = 0; i < 40; i++) step(0, 1, 1);
    // Reset mid-operation at count 9
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    chk("pre_rst_cnt", 32'(count), 32'd9);
    step(1, 1, 0);
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_addr", 32'(wr_addr), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("gray_after3", 32'(wr_gray), 32'h02);
    // Randomised phases with varying write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
